// File: rtl/mem_loader_if.sv
// Byte-stream in / RAM write-port out bundle for mem_loader.
interface mem_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned ADDRW = $clog2(DEPTH);

  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [ADDRW:0]   len;
  logic             abort;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;

  // Requester side: issues loads and supplies the byte stream.
  modport master (
    output start, base_addr, len, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  // Loader side.
  modport slave (
    input  start, base_addr, len, abort, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/mem_loader.sv
// Assembles a little-endian byte stream into WIDTH-bit words and writes
// len consecutive RAM words starting at base_addr, wrapping modulo DEPTH.
module mem_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_loader_if.slave  bus
);
  localparam int unsigned ADDRW  = $clog2(DEPTH);
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NBYTES - 1);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW:0]   ONE_LEFT  = (ADDRW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   rem_q, rem_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             in_ready_q, in_ready_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer_c;
  logic [WIDTH-1:0] merged_c;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    asm_d     = asm_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    xfer_c    = in_ready_q & bus.in_valid & ~bus.abort;
    merged_c  = asm_q;
    merged_c[{idx_q, 3'b000} +: 8] = bus.in_data;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.len != '0) begin
            addr_d  = bus.base_addr;
            rem_d   = bus.len;
            idx_d   = '0;
            asm_d   = '0;
            state_d = S_COLLECT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_COLLECT: begin
        if (xfer_c) begin
          asm_d = merged_c;
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            wr_addr_d = addr_q;
            wr_data_d = merged_c;
            state_d   = S_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == ONE_LEFT) begin
          state_d = S_DONE;
        end else begin
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over everything; a partial word is thrown away.
    if (bus.abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      asm_d   = '0;
    end

    in_ready_d = (state_d == S_COLLECT);
    wr_en_d    = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      asm_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Abort suppresses the handshake, write and done strobes in its own cycle.
  assign bus.in_ready = in_ready_q & ~bus.abort;
  assign bus.wr_en    = wr_en_q & ~bus.abort;
  assign bus.done     = done_q & ~bus.abort;
  assign bus.busy     = busy_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
endmodule
